// File: rtl/avg_window_ctrl.sv
// Window controller for the moving-average accumulator: owns the window exponent,
// sequences clear/refill on every change, gates samples and normalises the sum.
module avg_window_ctrl #(
  parameter int DATA_WIDTH = 10,
  parameter int ACC_POW    = 7,
  localparam int ACC_WIDTH = DATA_WIDTH + ACC_POW
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic [ACC_POW-1:0]    cfg_pow,
  input  logic                  cfg_wr,
  input  logic [DATA_WIDTH-1:0] smp_data,
  input  logic                  smp_valid,
  output logic                  acc_sclr,
  output logic [ACC_POW-1:0]    acc_delay,
  output logic [DATA_WIDTH-1:0] acc_data,
  output logic                  acc_valid,
  input  logic [ACC_WIDTH-1:0]  acc_q,
  input  logic                  acc_q_valid,
  output logic [DATA_WIDTH-1:0] avg_data,
  output logic                  avg_valid,
  output logic                  settled,
  output logic [ACC_POW-1:0]    cur_pow,
  output logic [7:0]            drop_cnt
);
  localparam int CW = ACC_POW + 1;

  typedef enum logic [1:0] {CLEAR, FILL, RUN} state_t;

  state_t             state, state_d;
  logic               boot;
  logic [CW-1:0]      fill_cnt, fill_cnt_d, fill_last;
  logic [ACC_POW-1:0] pow_clamped;
  logic               drop;

  assign pow_clamped = (cfg_pow > ACC_POW'(ACC_POW - 1)) ? ACC_POW'(ACC_POW - 1) : cfg_pow;
  assign fill_last   = (CW'(1) << cur_pow) - CW'(1);

  // boot marks the idle cycle between reset release and the first CLEAR pulse
  assign acc_sclr = (state == CLEAR) && !boot;
  assign settled  = (state == RUN);

  // Input stage and accumulator clear must agree: anything that would land in
  // the register stage while the clear is pending or active is discarded.
  assign drop = cfg_wr || acc_sclr || boot;

  always_comb begin
    state_d    = state;
    fill_cnt_d = fill_cnt;
    if (cfg_wr) begin
      state_d    = CLEAR;
      fill_cnt_d = '0;
    end else begin
      case (state)
        CLEAR: if (!boot) state_d = FILL;
        FILL: begin
          if (acc_q_valid) begin
            if (fill_cnt == fill_last) state_d = RUN;
            else fill_cnt_d = fill_cnt + CW'(1);
          end
        end
        default: state_d = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= CLEAR;
      boot      <= 1'b1;
      fill_cnt  <= '0;
      cur_pow   <= '0;
      acc_delay <= ACC_POW'(1);
      drop_cnt  <= '0;
      acc_data  <= '0;
      acc_valid <= 1'b0;
      avg_data  <= '0;
      avg_valid <= 1'b0;
    end else begin
      state    <= state_d;
      boot     <= 1'b0;
      fill_cnt <= fill_cnt_d;
      if (cfg_wr) begin
        cur_pow   <= pow_clamped;
        acc_delay <= ACC_POW'(1) << pow_clamped;
      end
      // a sample coinciding with cfg_wr is counted against the freshly cleared counter
      if (cfg_wr)
        drop_cnt <= 8'(smp_valid);
      else if (acc_sclr && smp_valid && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      acc_valid <= smp_valid && !drop;
      if (smp_valid && !drop) acc_data <= smp_data;
      // suppress results in the clear cycle and the one after it
      avg_valid <= acc_q_valid && !acc_sclr && (state_d != CLEAR);
      if (acc_q_valid) avg_data <= DATA_WIDTH'(acc_q >> cur_pow);
    end
  end
endmodule

// File: tb/tb_avg_window_ctrl.sv
// Bench for avg_window_ctrl: behavioural accumulator, directed streams, scoreboard.
module tb_avg_window_ctrl;
  localparam int DW = 10;
  localparam int AP = 7;
  localparam int AW = DW + AP;

  logic          clock = 1'b0;
  logic          aclr  = 1'b1;
  logic [AP-1:0] cfg_pow = '0;
  logic          cfg_wr = 1'b0;
  logic [DW-1:0] smp_data = '0;
  logic          smp_valid = 1'b0;
  logic          acc_sclr;
  logic [AP-1:0] acc_delay;
  logic [DW-1:0] acc_data;
  logic          acc_valid;
  logic [AW-1:0] acc_q;
  logic          acc_q_valid;
  logic [DW-1:0] avg_data;
  logic          avg_valid;
  logic          settled;
  logic [AP-1:0] cur_pow;
  logic [7:0]    drop_cnt;

  avg_window_ctrl #(.DATA_WIDTH(DW), .ACC_POW(AP)) dut (
    .clock(clock), .aclr(aclr), .cfg_pow(cfg_pow), .cfg_wr(cfg_wr),
    .smp_data(smp_data), .smp_valid(smp_valid), .acc_sclr(acc_sclr),
    .acc_delay(acc_delay), .acc_data(acc_data), .acc_valid(acc_valid),
    .acc_q(acc_q), .acc_q_valid(acc_q_valid), .avg_data(avg_data),
    .avg_valid(avg_valid), .settled(settled), .cur_pow(cur_pow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  // Accumulator stand-in: sum of the last acc_delay accepted samples, 2-cycle latency,
  // sclr empties the window and the result pipeline.
  int            hist[$];
  logic [AW-1:0] p1_q, p2_q;
  logic          p1_v, p2_v;
  assign acc_q       = p2_q;
  assign acc_q_valid = p2_v;

  always @(posedge clock or posedge aclr) begin
    int s;
    if (aclr) begin
      hist.delete();
      p1_v <= 1'b0; p2_v <= 1'b0; p1_q <= '0; p2_q <= '0;
    end else if (acc_sclr) begin
      hist.delete();
      p1_v <= 1'b0; p2_v <= 1'b0;
    end else begin
      p2_v <= p1_v; p2_q <= p1_q;
      p1_v <= acc_valid;
      if (acc_valid) begin
        hist.push_back(int'(acc_data));
        while (hist.size() > int'(acc_delay)) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += hist[i];
        p1_q <= AW'(s);
      end
    end
  end

  typedef struct packed {
    logic [DW-1:0] d;
    logic          s;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_sclr = 0;
  logic sb_en = 1'b1;
  logic sclr_prev = 1'b0;

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, want, $time);
  endtask

  // Monitor: pops one expectation per avg_valid and polices the clear mask.
  always @(negedge clock) begin
    exp_t e;
    if (acc_sclr) n_sclr++;
    if (acc_sclr || sclr_prev) chk("avg_valid_masked", int'(avg_valid), 0);
    if (avg_valid && sb_en) begin
      if (exp_q.size() == 0) chk("unexpected_avg", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("avg_data", int'(avg_data), int'(e.d));
        chk("settled", int'(settled), int'(e.s));
      end
    end
    sclr_prev = acc_sclr;
  end

  task automatic drive(input logic v, input int d, input logic w, input int p,
                       input logic ex, input int ed, input logic es);
    exp_t e;
    @(negedge clock);
    smp_valid = v; smp_data = DW'(d); cfg_wr = w; cfg_pow = AP'(p);
    if (ex) begin
      e.d = DW'(ed); e.s = es;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic drain(input string name);
    int i;
    idle(1);
    for (i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      chk({name, "_drain_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    idle(6);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_acc_sclr"}, int'(acc_sclr), 0);
    chk({tag, "_acc_valid"}, int'(acc_valid), 0);
    chk({tag, "_acc_data"}, int'(acc_data), 0);
    chk({tag, "_acc_delay"}, int'(acc_delay), 1);
    chk({tag, "_avg_valid"}, int'(avg_valid), 0);
    chk({tag, "_avg_data"}, int'(avg_data), 0);
    chk({tag, "_settled"}, int'(settled), 0);
    chk({tag, "_cur_pow"}, int'(cur_pow), 0);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp_exp[12] = '{0, 0, 0, 0, 1, 1, 2, 3, 4, 5, 6, 7};
    int sc0, n;

    // Reset state, then constant 100 with pow 0
    repeat (3) @(negedge clock);
    check_reset_vals("rst");
    sc0 = n_sclr;
    @(negedge clock);
    aclr = 1'b0; smp_valid = 1'b1; smp_data = DW'(100);  // idle cycle after release
    drive(1'b1, 100, 1'b0, 0, 1'b0, 0, 1'b0);            // CLEAR cycle: dropped
    for (int i = 0; i < 8; i++) drive(1'b1, 100, 1'b0, 0, 1'b1, 100, 1'b1);
    drain("p1");
    chk("p1_drop_cnt", int'(drop_cnt), 1);
    chk("p1_sclr_cycles", n_sclr - sc0, 1);

    // pow 3 ramp; sample alongside cfg_wr is dropped and counted
    sc0 = n_sclr;
    drive(1'b1, 999, 1'b1, 3, 1'b0, 0, 1'b0);
    idle(1);
    for (int i = 0; i < 12; i++) drive(1'b1, i, 1'b0, 3, 1'b1, ramp_exp[i], i >= 7);
    drain("p2");
    chk("p2_drop_cnt", int'(drop_cnt), 1);
    chk("p2_cur_pow", int'(cur_pow), 3);
    chk("p2_acc_delay", int'(acc_delay), 8);
    chk("p2_sclr_cycles", n_sclr - sc0, 1);

    // Clamp 9 -> 6, full-scale input over a 64-sample window
    drive(1'b0, 0, 1'b1, 9, 1'b0, 0, 1'b0);
    idle(1);
    chk("p3_cur_pow", int'(cur_pow), 6);
    chk("p3_acc_delay", int'(acc_delay), 64);
    for (int i = 0; i < 70; i++) begin
      n = (i + 1 < 64) ? i + 1 : 64;
      drive(1'b1, 1023, 1'b0, 9, 1'b1, (n * 1023) / 64, i >= 63);
    end
    drain("p3");
    chk("p3_avg_data_full", int'(avg_data), 1023);
    chk("p3_drop_cnt", int'(drop_cnt), 0);

    // pow 5 fill interrupted by back-to-back cfg_wr (pow 2 then 4) while streaming
    sc0 = n_sclr;
    drive(1'b0, 0, 1'b1, 5, 1'b0, 0, 1'b0);
    idle(1);
    for (int j = 0; j < 10; j++) drive(1'b1, 50, 1'b0, 5, j < 7, ((j + 1) * 50) / 32, 1'b0);
    drive(1'b1, 50, 1'b1, 2, 1'b0, 0, 1'b0);
    drive(1'b1, 50, 1'b1, 4, 1'b0, 0, 1'b0);
    drive(1'b1, 50, 1'b0, 4, 1'b0, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      n = (k + 1 < 16) ? k + 1 : 16;
      drive(1'b1, 200, 1'b0, 4, 1'b1, (n * 200) / 16, k >= 15);
    end
    drain("p4");
    chk("p4_cur_pow", int'(cur_pow), 4);
    chk("p4_acc_delay", int'(acc_delay), 16);
    chk("p4_drop_cnt", int'(drop_cnt), 2);
    chk("p4_sclr_cycles", n_sclr - sc0, 3);

    // Asynchronous reset while streaming in RUN
    sb_en = 1'b0;
    for (int i = 0; i < 6; i++) drive(1'b1, 200, 1'b0, 4, 1'b0, 0, 1'b0);
    chk("p5_settled_before", int'(settled), 1);
    #2 aclr = 1'b1;
    #1 check_reset_vals("aclr");
    exp_q.delete();
    sb_en = 1'b1;
    sc0 = n_sclr;
    @(negedge clock);
    aclr = 1'b0; smp_valid = 1'b1; smp_data = DW'(77);
    drive(1'b1, 77, 1'b0, 4, 1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 77, 1'b0, 4, 1'b1, 77, 1'b1);
    drain("p5");
    chk("p5_drop_cnt", int'(drop_cnt), 1);
    chk("p5_cur_pow", int'(cur_pow), 0);
    chk("p5_acc_delay", int'(acc_delay), 1);
    chk("p5_sclr_cycles", n_sclr - sc0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
